// File: rtl/mul_accumulator.sv
// mul_accumulator
//
// Sums a fixed number (COUNT) of 18-bit unsigned products per block with
// saturation, then presents the block total in a held output register.
// Input beats and output results each use a valid/ready handshake.
//
// Parameters:
//   COUNT  products per block (1..255)
//   ACC_W  accumulator / result width (>= 18)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   product beat offered
//   in_ready   beat accepted when in_valid & in_ready (combinational)
//   prod_lo    product bits [8:0]
//   prod_hi    product bits [17:9]
//   in_clear   abort current block; blocks acceptance this cycle
//   out_valid  block result held in output register
//   out_ready  consumer takes result when out_valid & out_ready
//   acc_out    block total
//   acc_ovf    block saturated (qualified by out_valid)

module mul_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       prod_lo,
    input  logic [8:0]       prod_hi,
    input  logic             in_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf
);

    localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             ovf;

    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum;
    logic             sat;
    logic [ACC_W-1:0] sat_sum;
    logic             last;
    logic             accept;
    logic             consume;

    // One extra bit of headroom: a product is < 2^18 <= 2^ACC_W, so the
    // carry out of acc + p is exactly the overflow condition.
    assign prod_ext = (ACC_W + 1)'({prod_hi, prod_lo});
    assign sum      = {1'b0, acc} + prod_ext;
    assign sat      = sum[ACC_W];
    assign sat_sum  = sat ? '1 : sum[ACC_W-1:0];

    assign last     = (cnt == LAST_CNT);

    // Only the final beat of a block needs the output register, so only it
    // stalls on an unconsumed result; a consume in the same cycle frees it.
    assign in_ready = rst_n & ~in_clear & ~(last & out_valid & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            acc_ovf   <= 1'b0;
        end else begin
            // Block accumulation state
            if (in_clear) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (accept) begin
                if (last) begin
                    acc <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                end else begin
                    acc <= sat_sum;
                    cnt <= cnt + 8'd1;
                    ovf <= ovf | sat;
                end
            end

            // Output register: a final beat reloads it even while the old
            // result is being consumed, so back-to-back blocks have no bubble.
            if (accept && last) begin
                acc_out   <= sat_sum;
                acc_ovf   <= ovf | sat;
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// Testbench for mul_accumulator. Three instances share one stimulus stream:
//   [0] COUNT=4 ACC_W=24, [1] COUNT=4 ACC_W=19, [2] COUNT=1 ACC_W=24.
// A behavioural model tracks each instance's block sum with plain arithmetic.

module tb_mul_accumulator;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic [8:0] prod_lo;
    logic [8:0] prod_hi;
    logic in_clear;
    logic out_ready;

    logic [2:0]       rdy;
    logic [2:0]       ov;
    logic [2:0]       ovf;
    logic [2:0][23:0] acc_o;
    logic [18:0]      acc_b;

    int n_checks = 0;
    int n_fail   = 0;

    mul_accumulator #(.COUNT(4), .ACC_W(24)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .prod_lo(prod_lo), .prod_hi(prod_hi), .in_clear(in_clear),
        .out_valid(ov[0]), .out_ready(out_ready), .acc_out(acc_o[0]), .acc_ovf(ovf[0]));

    mul_accumulator #(.COUNT(4), .ACC_W(19)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .prod_lo(prod_lo), .prod_hi(prod_hi), .in_clear(in_clear),
        .out_valid(ov[1]), .out_ready(out_ready), .acc_out(acc_b), .acc_ovf(ovf[1]));

    assign acc_o[1] = 24'(acc_b);

    mul_accumulator #(.COUNT(1), .ACC_W(24)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .prod_lo(prod_lo), .prod_hi(prod_hi), .in_clear(in_clear),
        .out_valid(ov[2]), .out_ready(out_ready), .acc_out(acc_o[2]), .acc_ovf(ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int     CNT [3] = '{4, 4, 1};
    int     AW  [3] = '{24, 19, 24};
    int     m_n   [3];   // products taken so far in the current block
    longint m_sum [3];   // saturated running sum of the current block
    bit     m_sat [3];   // any saturation so far in the current block
    bit     m_ov  [3];   // a result is waiting for the consumer
    longint m_out [3];
    bit     m_oovf[3];

    function automatic bit exp_ready(int i);
        return rst_n && !in_clear && !((m_n[i] == CNT[i] - 1) && m_ov[i] && !out_ready);
    endfunction

    // Advance one clock edge, updating the model from the inputs in force
    // before the edge. Returns 1 time unit after the edge.
    task automatic tick();
        bit     take[3];
        bit     fin[3];
        bit     r, clr, ordy;
        longint pv, mx, s;
        bit     sat;
        pv   = longint'({prod_hi, prod_lo});
        r    = rst_n;
        clr  = in_clear;
        ordy = out_ready;
        for (int i = 0; i < 3; i++) begin
            take[i] = in_valid && exp_ready(i);
            fin[i]  = take[i] && (m_n[i] == CNT[i] - 1);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                m_n[i] = 0; m_sum[i] = 0; m_sat[i] = 0;
                m_ov[i] = 0; m_out[i] = 0; m_oovf[i] = 0;
            end else begin
                mx  = (longint'(1) << AW[i]) - 1;
                s   = m_sum[i] + pv;
                sat = (s > mx);
                if (sat) s = mx;
                if (m_ov[i] && ordy && !fin[i]) m_ov[i] = 0;
                if (clr) begin
                    m_n[i] = 0; m_sum[i] = 0; m_sat[i] = 0;
                end else if (fin[i]) begin
                    m_out[i]  = s;
                    m_oovf[i] = m_sat[i] | sat;
                    m_ov[i]   = 1;
                    m_n[i] = 0; m_sum[i] = 0; m_sat[i] = 0;
                end else if (take[i]) begin
                    m_sum[i] = s;
                    m_n[i]   = m_n[i] + 1;
                    m_sat[i] = m_sat[i] | sat;
                end
            end
        end
        #1;
    endtask

    task automatic set_p(input int v);
        logic [17:0] p;
        p = 18'(v);
        prod_hi = p[17:9];
        prod_lo = p[8:0];
    endtask

    // Abort any partial block on all instances without touching outputs.
    task automatic clear_blocks();
        in_valid = 1'b0;
        in_clear = 1'b1;
        tick();
        in_clear = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_clear = 1'b0; out_ready = 1'b0;
        set_p(5);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ov[i] !== 1'b0 || acc_o[i] !== 24'd0 || ovf[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got ov=%b acc=%0d ovf=%b, need 0/0/0", i, ov[i], acc_o[i], ovf[i]);
            end
            n_checks++;
            if (rdy[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_in_ready[%0d]: got %b, need 0", i, rdy[i]);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rdy[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_in_ready[%0d]: got %b, need 1", i, rdy[i]);
            end
        end
    endtask

    task automatic test_max_products();
        out_ready = 1'b1;
        clear_blocks();
        tick();  // drain any pending result
        in_valid = 1'b1;
        set_p((510 << 9) | 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (ov[0] !== (k == 3)) begin
                n_fail++;
                $display("FAIL max_out_valid beat %0d: got %b, need %b", k, ov[0], (k == 3));
            end
        end
        n_checks++;
        if (acc_o[0] !== 24'd1044484 || ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL max_sum: got %0d ovf=%b, need 1044484 ovf=0", acc_o[0], ovf[0]);
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (ov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL max_one_cycle: out_valid got %b, need 0", ov[0]);
        end
    endtask

    task automatic test_backpressure();
        int vals[8] = '{1, 2, 3, 4, 10, 10, 10, 10};
        out_ready = 1'b1;
        clear_blocks();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            set_p(vals[k]);
            tick();
        end
        n_checks++;
        if (ov[0] !== 1'b1 || acc_o[0] !== 24'd10) begin
            n_fail++;
            $display("FAIL bp_hold: got ov=%b acc=%0d, need 1/10", ov[0], acc_o[0]);
        end
        set_p(vals[7]);
        #1;
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: in_ready got %b, need 0", rdy[0]);
        end
        tick();
        n_checks++;
        if (rdy[0] !== 1'b0 || acc_o[0] !== 24'd10) begin
            n_fail++;
            $display("FAIL bp_stall2: got rdy=%b acc=%0d, need 0/10", rdy[0], acc_o[0]);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: in_ready got %b, need 1", rdy[0]);
        end
        tick();
        n_checks++;
        if (ov[0] !== 1'b1 || acc_o[0] !== 24'd40) begin
            n_fail++;
            $display("FAIL bp_reload: got ov=%b acc=%0d, need 1/40", ov[0], acc_o[0]);
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (ov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_consume: out_valid got %b, need 0", ov[0]);
        end
    endtask

    task automatic test_saturation();
        int vals[8] = '{261121, 261121, 261121, 0, 1, 1, 1, 1};
        out_ready = 1'b1;
        clear_blocks();
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_p(vals[k]);
            tick();
            if (k == 3) begin
                n_checks++;
                if (acc_o[1] !== 24'd524287 || ovf[1] !== 1'b1 || ov[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sat_block: got acc=%0d ovf=%b ov=%b, need 524287/1/1", acc_o[1], ovf[1], ov[1]);
                end
            end
        end
        n_checks++;
        if (acc_o[1] !== 24'd4 || ovf[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_next_block: got acc=%0d ovf=%b, need 4/0", acc_o[1], ovf[1]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        clear_blocks();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_p(6);
        for (int k = 0; k < 4; k++) tick();   // pending result 24
        set_p(100);
        tick();
        tick();
        in_clear = 1'b1;
        set_p(50);
        #1;
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_in_ready: got %b, need 0", rdy[0]);
        end
        tick();
        in_clear = 1'b0;
        n_checks++;
        if (ov[0] !== 1'b1 || acc_o[0] !== 24'd24) begin
            n_fail++;
            $display("FAIL clear_keeps_output: got ov=%b acc=%0d, need 1/24", ov[0], acc_o[0]);
        end
        out_ready = 1'b1;
        set_p(5);
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (ov[0] !== 1'b1 || acc_o[0] !== 24'd20) begin
            n_fail++;
            $display("FAIL clear_restart: got ov=%b acc=%0d, need 1/20", ov[0], acc_o[0]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_block();
        out_ready = 1'b1;
        clear_blocks();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_p(2);
        for (int k = 0; k < 4; k++) tick();   // pending result 8
        set_p(9);
        tick();
        tick();
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (ov[0] !== 1'b0 || acc_o[0] !== 24'd0 || ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got ov=%b acc=%0d ovf=%b, need 0/0/0", ov[0], acc_o[0], ovf[0]);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_p(7);
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (ov[0] !== 1'b1 || acc_o[0] !== 24'd28) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got ov=%b acc=%0d, need 1/28", ov[0], acc_o[0]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int vals[3] = '{3, 5, 7};
        out_ready = 1'b1;
        clear_blocks();
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_p(vals[k]);
            #1;
            n_checks++;
            if (rdy[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_in_ready beat %0d: got %b, need 1", k, rdy[2]);
            end
            tick();
            n_checks++;
            if (ov[2] !== 1'b1 || acc_o[2] !== 24'(vals[k])) begin
                n_fail++;
                $display("FAIL stream_out beat %0d: got ov=%b acc=%0d, need 1/%0d", k, ov[2], acc_o[2], vals[k]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            in_clear  = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            set_p(($urandom_range(0, 3) == 0) ? 262143 - int'($urandom_range(0, 15))
                                              : int'($urandom_range(0, 262143)));
            #1;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (rdy[i] !== exp_ready(i)) begin
                    n_fail++;
                    $display("FAIL rand_in_ready[%0d] cyc %0d: got %b, need %b", i, c, rdy[i], exp_ready(i));
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (ov[i] !== m_ov[i] || acc_o[i] !== 24'(m_out[i]) || ovf[i] !== m_oovf[i]) begin
                    n_fail++;
                    $display("FAIL rand_out[%0d] cyc %0d: got ov=%b acc=%0d ovf=%b, need %b/%0d/%b",
                             i, c, ov[i], acc_o[i], ovf[i], m_ov[i], m_out[i], m_oovf[i]);
                end
            end
        end
        rst_n = 1'b1; in_clear = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_clear = 1'b0; out_ready = 1'b0;
        prod_hi = '0; prod_lo = '0;
        test_reset();
        test_max_products();
        test_backpressure();
        test_saturation();
        test_clear();
        test_reset_mid_block();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
